wb_arbiter_2: RTL and testbench

Two-master Wishbone bus arbiter that shares a single slave port, typically a multiplexer such as the three-port address-decoding mux, between two bus masters. It grants the bus for a whole Wishbone cycle, held while the granted master keeps CYC asserted. It uses either fixed-priority or round-robin selection, and it isolates the non-granted master completely. An optional watchdog terminates stalled transfers with an error.

---
 rtl/wb_arb_pkg.sv | 31 +++
 rtl/wb_arb_timeout.sv | 36 +++
 rtl/wb_arbiter_2.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter_2.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant state
// encoding, arbitration mode constants and the winner-selection helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } grant_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Picks the next owner among the current requesters. Under contention,
  // round-robin favours the master that did not hold the last grant;
  // fixed priority always favours master 0.
  function automatic grant_state_e pick_winner(input logic req0,
                                               input logic req1,
                                               input logic rr_mode,
                                               input logic last_grant);
    if (req0 && req1) begin
      return (rr_mode && !last_grant) ? GRANT1 : GRANT0;
    end else if (req0) begin
      return GRANT0;
    end else if (req1) begin
      return GRANT1;
    end
    return IDLE;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Watchdog for the arbiter's slave port: counts consecutive cycles where
// the slave sees stb with no response and flags a one-cycle timeout when
// the count reaches TIMEOUT_CYCLES.
module wb_arb_timeout
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic resp,
  input  logic grant_change,
  output logic timeout
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;

  assign timeout = (count_q == LIMIT);

  // Stall counter: restarts on any response, idle strobe, owner change or
  // after it has fired, so each stall produces a single error pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst || resp || !stb || grant_change || timeout) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone arbiter sharing one slave port. A grant lasts for a
// whole bus cycle (while the owner holds cyc); selection is round-robin or
// fixed priority. The non-granted master sees an all-zero response.
// Optional watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter_2
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int TIMEOUT_CYCLES  = 1024
)
(
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,

  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i
);

  localparam bit RR_MODE = (ARB_ROUND_ROBIN == ARB_RR);

  grant_state_e state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         grant_change;
  logic         timeout;

  // Next grant: re-arbitrate only when idle or when the owner released cyc.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) ||
        (state_q == GRANT0 && !wbm0_cyc_i) ||
        (state_q == GRANT1 && !wbm1_cyc_i)) begin
      state_d = pick_winner(wbm0_cyc_i, wbm1_cyc_i, RR_MODE, last_grant_q);
    end
    if (state_d != state_q && state_d != IDLE) begin
      last_grant_d = (state_d == GRANT1);
    end
  end

  assign grant_change = (state_d != state_q);

  // Grant register and round-robin pointer; last_grant resets to 1 so
  // master 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk          (clk),
    .rst          (rst),
    .stb          (wbs_stb_o),
    .resp         (wbs_ack_i | wbs_err_i | wbs_rty_i),
    .grant_change (grant_change),
    .timeout      (timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_grant_change;
  assign unused_grant_change = grant_change;
  assign timeout = 1'b0;
`endif

  // Bus steering: owner's request goes to the slave, slave response goes
  // back to the owner only; everything else is held at zero.
  always_comb begin
    wbs_adr_o  = '0;
    wbs_dat_o  = '0;
    wbs_we_o   = 1'b0;
    wbs_sel_o  = '0;
    wbs_stb_o  = 1'b0;
    wbs_cyc_o  = 1'b0;
    wbm0_dat_o = '0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm0_rty_o = 1'b0;
    wbm1_dat_o = '0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    wbm1_rty_o = 1'b0;
    case (state_q)
      GRANT0: begin
        wbs_adr_o  = wbm0_adr_i;
        wbs_dat_o  = wbm0_dat_i;
        wbs_we_o   = wbm0_we_i;
        wbs_sel_o  = wbm0_sel_i;
        wbs_stb_o  = wbm0_stb_i;
        wbs_cyc_o  = wbm0_cyc_i;
        wbm0_dat_o = wbs_dat_i;
        wbm0_ack_o = wbs_ack_i;
        wbm0_err_o = wbs_err_i | timeout;
        wbm0_rty_o = wbs_rty_i;
      end
      GRANT1: begin
        wbs_adr_o  = wbm1_adr_i;
        wbs_dat_o  = wbm1_dat_i;
        wbs_we_o   = wbm1_we_i;
        wbs_sel_o  = wbm1_sel_i;
        wbs_stb_o  = wbm1_stb_i;
        wbs_cyc_o  = wbm1_cyc_i;
        wbm1_dat_o = wbs_dat_i;
        wbm1_ack_o = wbs_ack_i;
        wbm1_err_o = wbs_err_i | timeout;
        wbm1_rty_o = wbs_rty_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Testbench for wb_arbiter_2: a round-robin and a fixed-priority instance
// share the same master and slave stimulus; a bus-ownership model checks
// every output of both instances every cycle.
module tb_wb_arbiter_2;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic          m_we  [2];
  logic [SW-1:0] m_sel [2];
  logic          m_stb [2];
  logic          m_cyc [2];

  logic [DW-1:0] sl_dat;
  logic          sl_ack, sl_err, sl_rty;

  // [instance][master]; instance 0 = round robin, 1 = fixed priority
  logic [DW-1:0] o_dat [2][2];
  logic          o_ack [2][2];
  logic          o_err [2][2];
  logic          o_rty [2][2];

  logic [AW-1:0] s_adr [2];
  logic [DW-1:0] s_dat [2];
  logic          s_we  [2];
  logic [SW-1:0] s_sel [2];
  logic          s_stb [2];
  logic          s_cyc [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    wb_arbiter_2 #(
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW),
      .SELECT_WIDTH    (SW),
      .ARB_ROUND_ROBIN ((k == 0) ? 1 : 0),
      .TIMEOUT_CYCLES  (TO)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .wbm0_adr_i (m_adr[0]),
      .wbm0_dat_i (m_dat[0]),
      .wbm0_we_i  (m_we[0]),
      .wbm0_sel_i (m_sel[0]),
      .wbm0_stb_i (m_stb[0]),
      .wbm0_cyc_i (m_cyc[0]),
      .wbm0_dat_o (o_dat[k][0]),
      .wbm0_ack_o (o_ack[k][0]),
      .wbm0_err_o (o_err[k][0]),
      .wbm0_rty_o (o_rty[k][0]),
      .wbm1_adr_i (m_adr[1]),
      .wbm1_dat_i (m_dat[1]),
      .wbm1_we_i  (m_we[1]),
      .wbm1_sel_i (m_sel[1]),
      .wbm1_stb_i (m_stb[1]),
      .wbm1_cyc_i (m_cyc[1]),
      .wbm1_dat_o (o_dat[k][1]),
      .wbm1_ack_o (o_ack[k][1]),
      .wbm1_err_o (o_err[k][1]),
      .wbm1_rty_o (o_rty[k][1]),
      .wbs_adr_o  (s_adr[k]),
      .wbs_dat_o  (s_dat[k]),
      .wbs_we_o   (s_we[k]),
      .wbs_sel_o  (s_sel[k]),
      .wbs_stb_o  (s_stb[k]),
      .wbs_cyc_o  (s_cyc[k]),
      .wbs_dat_i  (sl_dat),
      .wbs_ack_i  (sl_ack),
      .wbs_err_i  (sl_err),
      .wbs_rty_i  (sl_rty)
    );
  end

  // Reference model: who owns the bus (-1 = nobody), who owned it last,
  // and how long the owner's strobe has gone unanswered.
  int owner [2] = '{-1, -1};
  int last  [2] = '{1, 1};
  int stall [2] = '{0, 0};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      logic [127:0] exp_v;
      logic [127:0] obs_v;
      logic         to;
      int           o;
      string        nm;
      o  = owner[k];
      nm = (k == 0) ? "rr" : "fp";
      to = 1'b0;
`ifdef WB_ARBITER_TIMEOUT_EN
      to = (o >= 0) && (stall[k] == TO);
`endif
      exp_v = '0;
      if (o >= 0) exp_v = 128'({m_adr[o], m_dat[o], m_we[o], m_sel[o], m_stb[o], m_cyc[o]});
      obs_v = 128'({s_adr[k], s_dat[k], s_we[k], s_sel[k], s_stb[k], s_cyc[k]});
      check($sformatf("%s/%s/slave", ph, nm), obs_v, exp_v);
      for (int m = 0; m < 2; m++) begin
        exp_v = (o == m) ? 128'({sl_dat, sl_ack, sl_err | to, sl_rty}) : '0;
        obs_v = 128'({o_dat[k][m], o_ack[k][m], o_err[k][m], o_rty[k][m]});
        check($sformatf("%s/%s/m%0d", ph, nm, m), obs_v, exp_v);
      end
    end
  endtask

  task automatic update_model();
    for (int k = 0; k < 2; k++) begin
      int   nw;
      logic stb_seen;
      logic resp;
      if (rst) begin
        owner[k] = -1;
        last[k]  = 1;
        stall[k] = 0;
      end else begin
        if (owner[k] >= 0 && m_cyc[owner[k]])  nw = owner[k];
        else if (m_cyc[0] && m_cyc[1])         nw = (k == 0) ? 1 - last[k] : 0;
        else if (m_cyc[0])                     nw = 0;
        else if (m_cyc[1])                     nw = 1;
        else                                   nw = -1;
        stb_seen = 1'b0;
        if (owner[k] >= 0) stb_seen = m_stb[owner[k]];
        resp = sl_ack | sl_err | sl_rty;
        if (nw != owner[k] || resp || !stb_seen || stall[k] == TO) stall[k] = 0;
        else stall[k]++;
        if (nw != owner[k] && nw >= 0) last[k] = nw;
        owner[k] = nw;
      end
    end
  endtask

  // One bus cycle: inputs already applied; check mid-cycle, then advance.
  task automatic cycle(input string ph);
    @(negedge clk);
    check_all(ph);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic [AW-1:0] adr);
    m_cyc[m] = cyc;
    m_stb[m] = stb;
    m_adr[m] = adr;
    m_dat[m] = $urandom;
    m_we[m]  = 1'($urandom_range(0, 1));
    m_sel[m] = 4'($urandom_range(0, 15));
  endtask

  task automatic set_s(input logic ack, input logic err, input logic rty);
    sl_ack = ack;
    sl_err = err;
    sl_rty = rty;
    sl_dat = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, '0);
    set_m(1, 1'b0, 1'b0, '0);
    set_s(1'b0, 1'b0, 1'b0);
    cycle("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, '0);
    set_m(1, 1'b0, 1'b0, '0);
    set_s(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cycle("reset");
    rst = 1'b0;

    // Single master write, acked two cycles into the grant
    set_m(0, 1'b1, 1'b1, 32'h10);
    m_dat[0] = 32'hA5A5_A5A5;
    m_we[0]  = 1'b1;
    m_sel[0] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      set_s(i == 3, 1'b0, 1'b0);
      cycle("single");
    end
    set_m(0, 1'b0, 1'b0, '0);
    set_s(1'b0, 1'b0, 1'b0);
    cycle("single");

    // Contention straight after reset, handover, then contention again
    do_reset();
    set_m(0, 1'b1, 1'b1, 32'h100);
    set_m(1, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) begin set_s(i == 2, 1'b0, 1'b0); cycle("contend"); end
    set_m(0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin set_s(i == 2, 1'b0, 1'b0); cycle("handover"); end
    set_m(1, 1'b0, 1'b0, '0);
    cycle("handover");
    set_m(0, 1'b1, 1'b1, 32'h104);
    set_m(1, 1'b1, 1'b1, 32'h204);
    for (int i = 0; i < 3; i++) begin set_s(1'b1, 1'b0, 1'b0); cycle("contend2"); end

    // Both masters hammering with back-to-back 3-cycle bursts
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        set_m(0, j < 3, j < 3, 32'h300 + 32'(j));
        set_m(1, j < 3, j < 3, 32'h400 + 32'(j));
        set_s(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cycle("prio");
      end
    end

    // m1 holds its cycle through four transfers while m0 waits
    do_reset();
    set_m(1, 1'b1, 1'b1, 32'h500);
    set_s(1'b0, 1'b0, 1'b0);
    cycle("lock");
    set_m(0, 1'b1, 1'b1, 32'h600);
    for (int i = 0; i < 8; i++) begin
      set_s(i[0], 1'b0, 1'b0);
      cycle("lock");
    end
    set_m(1, 1'b0, 1'b0, '0);
    set_s(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("unlock");

    // Reset pulse while m0 is mid-transfer
    set_m(0, 1'b1, 1'b1, 32'h700);
    cycle("midrst");
    rst = 1'b1;
    cycle("midrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("midrst");

    // Slave never answers
    do_reset();
    set_m(0, 1'b1, 1'b1, 32'h800);
    set_s(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("stall");
    set_m(0, 1'b0, 1'b0, '0);
    cycle("stall");

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        logic c;
        c = m_cyc[m];
        if ($urandom_range(0, 3) == 0) c = ~c;
        set_m(m, c, c & 1'($urandom_range(0, 3) != 0), $urandom);
      end
      set_s($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle("random");
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
